// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchronizer, 4-state debounce FSM, press/release/long-press pulses.
// Latency: outputs assert DEBOUNCE_CYCLES+2 edges after the synchronizer first samples a new level.
// Backpressure: none; every output is a free-running registered level or single-cycle pulse.
// Optional feature: define BUTTON_LONG_PRESS_EN to build the hold counter and drive long_press.
module button_debounce #(
  parameter int CLOCK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES   = CLOCK_HZ / 50,
  parameter int LONG_PRESS_CYCLES = CLOCK_HZ,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s1_raw,
  output logic s1,
  output logic s1_press,
  output logic s1_release,
  output logic long_press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pin level when the button is not pressed; synchronizer resets here.
  localparam logic            IDLE_LVL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             p;

  // Normalized, synchronized button bit: 1 = pressed.
  assign p = sync2_q ^ ACTIVE_LOW;

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    sync1_d   = s1_raw;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        cnt_d = '0;
        if (p) state_d = CHECK_PRESS;
      end
      CHECK_PRESS: begin
        if (!p) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Counter is cleared rather than incremented so it can never wrap.
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!p) state_d = CHECK_RELEASE;
      end
      CHECK_RELEASE: begin
        if (p) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    s1_d = (state_d == PRESSED) || (state_d == CHECK_RELEASE);
  end

  // Synchronizer, FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      s1_q      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_q      <= s1_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign s1         = s1_q;
  assign s1_press   = press_q;
  assign s1_release = release_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;
  logic              long_q, long_d;

  // Hold timer: restarts on each accepted press, saturates, and fires long_press once per press.
  always_comb begin
    hold_d      = hold_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (press_d) begin
      hold_d      = '0;
      long_done_d = 1'b0;
    end else if ((state_q == PRESSED) || (state_q == CHECK_RELEASE)) begin
      if (hold_q == HOLD_LAST) begin
        if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  // Hold timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, ACTIVE_LOW=1.
// Stimulus pushes expected pulses and output levels (tagged with the clock edge) into queues;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_button_debounce;

  localparam int DEB = 8;
  localparam int LNG = 32;
  // Raw driven at a negedge: next edge is the first synchronizer sample (N), pulse after N+2+DEB.
  localparam int LAT = 1 + 2 + DEB;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic s1_raw;
  logic s1, s1_press, s1_release, long_press;

  always #5 clk = ~clk;

  button_debounce #(
    .CLOCK_HZ(1000),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_PRESS_CYCLES(LNG),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s1_raw(s1_raw),
    .s1(s1),
    .s1_press(s1_press),
    .s1_release(s1_release),
    .long_press(long_press)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { int kind; int edge_no; } evt_t;
  typedef struct { int edge_no; logic [3:0] lvl; } lvl_t;  // {s1, press, release, long}

  evt_t evt_q[$];
  lvl_t lvl_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   done  = 1'b0;
  string names [3] = '{"press", "release", "long_press"};

  task automatic exp_evt(input int kind, input int e);
    evt_t x;
    x.kind = kind;
    x.edge_no = e;
    evt_q.push_back(x);
  endtask

  task automatic exp_lvl(input int e, input logic [3:0] v);
    lvl_t x;
    x.edge_no = e;
    x.lvl = v;
    lvl_q.push_back(x);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: press and expect acceptance exactly LAT edges later.
  task automatic do_press(output int p);
    s1_raw = 1'b0;
    p = edge_cnt + LAT;
    exp_lvl(p - 1, 4'b0000);
    exp_lvl(p,     4'b1100);
    exp_lvl(p + 1, 4'b1000);
    exp_evt(EV_PRESS, p);
  endtask

  task automatic do_release(output int r);
    s1_raw = 1'b1;
    r = edge_cnt + LAT;
    exp_lvl(r - 1, 4'b1000);
    exp_lvl(r,     4'b0010);
    exp_lvl(r + 1, 4'b0000);
    exp_evt(EV_RELEASE, r);
  endtask

  // Monitor: compares every pulse and every scheduled level check.
  always @(negedge clk) begin
    logic [2:0] pulses;
    logic [3:0] got;
    evt_t e;
    lvl_t l;
    pulses = {long_press, s1_release, s1_press};
    got    = {s1, s1_press, s1_release, long_press};
    if (pulses != 3'b000) begin
      tests++;
      if ($countones(pulses) != 1) begin
        fails++;
        $display("FAIL pulse_exclusive at edge %0d: got pulses=%b, expected one-hot", edge_cnt, pulses);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (pulses[k]) begin
        tests++;
        if (evt_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_%s at edge %0d: got pulse, expected none", names[k], edge_cnt);
        end else begin
          e = evt_q.pop_front();
          if (e.kind != k || e.edge_no != edge_cnt) begin
            fails++;
            $display("FAIL event_%s: got %s at edge %0d, expected %s at edge %0d",
                     names[e.kind], names[k], edge_cnt, names[e.kind], e.edge_no);
          end
        end
      end
    end
    if (lvl_q.size() != 0 && lvl_q[0].edge_no <= edge_cnt) begin
      l = lvl_q.pop_front();
      tests++;
      if (l.edge_no != edge_cnt || got != l.lvl) begin
        fails++;
        $display("FAIL levels at edge %0d: got {s1,press,release,long}=%b, expected %b at edge %0d",
                 edge_cnt, got, l.lvl, l.edge_no);
      end
    end
    if (done) begin
      tests++;
      if (evt_q.size() != 0) begin
        fails++;
        $display("FAIL missing_pulses: got %0d outstanding, expected 0 (next %s at edge %0d)",
                 evt_q.size(), names[evt_q[0].kind], evt_q[0].edge_no);
      end
      tests++;
      if (lvl_q.size() != 0) begin
        fails++;
        $display("FAIL missing_level_checks: got %0d outstanding, expected 0", lvl_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  // Stimulus.
  initial begin
    int p, r;
    rst_n  = 1'b0;
    s1_raw = 1'b1;
    wait_neg(2);
    exp_lvl(edge_cnt + 1, 4'b0000);  // outputs held at 0 in reset
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(3);

    // Clean press then clean release.
    do_press(p);
    wait_neg(20);
    do_release(r);
    wait_neg(20);

    // Bounce: 5 low, 3 high, then low and held.
    s1_raw = 1'b0;
    wait_neg(5);
    s1_raw = 1'b1;
    wait_neg(3);
    do_press(p);
    wait_neg(20);
    do_release(r);
    wait_neg(20);

    // 3-cycle release glitch while pressed: no change.
    do_press(p);
    wait_neg(12);
    s1_raw = 1'b1;
    wait_neg(3);
    s1_raw = 1'b0;
    exp_lvl(edge_cnt + 12, 4'b1000);
    wait_neg(15);
    do_release(r);
    wait_neg(20);

    // Long hold of 60 cycles.
    do_press(p);
`ifdef BUTTON_LONG_PRESS_EN
    exp_evt(EV_LONG, p + LNG);
    exp_lvl(p + LNG, 4'b1001);
`else
    exp_lvl(p + LNG, 4'b1000);
`endif
    exp_lvl(p + LNG + 1, 4'b1000);
    wait_neg(60);
    do_release(r);
    wait_neg(20);

    // Reset while in CHECK_PRESS with counter at 5, button kept held.
    s1_raw = 1'b0;
    wait_neg(8);
    rst_n = 1'b0;
    exp_lvl(edge_cnt + 1, 4'b0000);
    wait_neg(3);
    rst_n = 1'b1;
    do_press(p);
    wait_neg(20);

    // Reset mid-hold, button released during reset: no pulse afterwards.
    rst_n = 1'b0;
    exp_lvl(edge_cnt + 1, 4'b0000);
    s1_raw = 1'b1;
    wait_neg(3);
    rst_n = 1'b1;
    exp_lvl(edge_cnt + 15, 4'b0000);
    wait_neg(30);

    done = 1'b1;
  end

endmodule
